// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state, requester and rw encodings for the memory bus arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_LDR  = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// arb_prio_pick: loader-priority grant decision with a starvation guard that forces the CPU through
module arb_prio_pick #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic cpu_req_i,
  input  logic ldr_req_i,
  output logic gnt_o,
  output logic gnt_ldr_o
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] starve_q, starve_d;
  always_comb begin
    gnt_o     = idle_i & (cpu_req_i | ldr_req_i);
    gnt_ldr_o = ldr_req_i & ~(cpu_req_i & (starve_q == CW'(MAX_HOLD)));
    starve_d  = starve_q;
    // a loader grant while the CPU waits can only happen below MAX_HOLD, so no explicit saturation
    if (idle_i)
      starve_d = (!cpu_req_i || !gnt_ldr_o) ? '0 : starve_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a single-port memory between CPU and loader through a fixed-latency
// access sequence with one-cycle acknowledges
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_rw,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              rw_q, rw_d, owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
  logic              gnt, gnt_ldr, last;

  arb_prio_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
    .clk      (CLK),
    .rst_n    (RST_N),
    .idle_i   (state_q == IDLE),
    .cpu_req_i(cpu_req),
    .ldr_req_i(ldr_req),
    .gnt_o    (gnt),
    .gnt_ldr_o(gnt_ldr)
  );

  assign last = (state_q == ACCESS) && (lat_q == '0);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rw_d        = rw_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: if (gnt) begin
        state_d = ACCESS;
        lat_d   = LW'(MEM_LAT - 1);
        owner_d = gnt_ldr;
        rw_d    = gnt_ldr ? ldr_rw : cpu_rw;
        addr_d  = gnt_ldr ? ldr_addr : cpu_addr;
        wdata_d = gnt_ldr ? ldr_wdata : cpu_wdata;
      end
      ACCESS: if (!last) lat_d = lat_q - 1'b1;
      else begin
        state_d = RESP;
        if (rw_q == RW_READ && owner_q == REQ_LDR) ldr_rdata_d = mem_rdata;
        if (rw_q == RW_READ && owner_q == REQ_CPU) cpu_rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      rw_q        <= RW_READ;
      owner_q     <= REQ_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      rw_q        <= rw_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end

  assign mem_en    = state_q == ACCESS;
  assign mem_rw    = ~(last & (rw_q == RW_WRITE));
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == RESP) && (owner_q == REQ_CPU);
  assign ldr_ack   = (state_q == RESP) && (owner_q == REQ_LDR);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench driving MEM_LAT=1 and MEM_LAT=3 arbiters from shared requesters
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;
  logic CLK = 0, RST_N = 0;
  logic cpu_req = 0, cpu_rw = 1, ldr_req = 0, ldr_rw = 1;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic [7:0] cpu_rdata1, ldr_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [7:0] cpu_rdata3, ldr_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic cpu_ack1, cpu_stall1, ldr_ack1, mem_en1, mem_rw1, owner1;
  logic cpu_ack3, cpu_stall3, ldr_ack3, mem_en3, mem_rw3, owner3;
  int cmp = 0, err = 0, wr3 = 0;
  logic [7:0] waddr3 = 0, wdata3 = 0;
  logic [8:0] exp_q[$];
  localparam logic [36:0] RST_VEC = 37'h1 << 33;
  wire [36:0] obs1 = {cpu_ack1, ldr_ack1, mem_en1, mem_rw1, mem_addr1, mem_wdata1, cpu_rdata1, ldr_rdata1, owner1};
  wire [36:0] obs3 = {cpu_ack3, ldr_ack3, mem_en3, mem_rw3, mem_addr3, mem_wdata3, cpu_rdata3, ldr_rdata3, owner3};

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'hB7;
  endfunction

  assign mem_rdata1 = pat(mem_addr1);
  assign mem_rdata3 = pat(mem_addr3);
  always @(posedge CLK)
    if (mem_en3 && !mem_rw3) begin
      wr3    <= wr3 + 1;
      waddr3 <= mem_addr3;
      wdata3 <= mem_wdata3;
    end

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .MAX_HOLD(4)) u1 (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
    .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata1), .ldr_ack(ldr_ack1),
    .mem_en(mem_en1), .mem_rw(mem_rw1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .owner(owner1)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .MAX_HOLD(4)) u3 (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
    .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata3), .ldr_ack(ldr_ack3),
    .mem_en(mem_en3), .mem_rw(mem_rw3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .owner(owner3)
  );

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    cmp++; if (obs1 !== RST_VEC) begin err++; $display("FAIL reset_u1: got %h exp %h", obs1, RST_VEC); end
    cmp++; if (obs3 !== RST_VEC) begin err++; $display("FAIL reset_u3: got %h exp %h", obs3, RST_VEC); end
    RST_N = 1;
    repeat (2) @(negedge CLK);
    cmp++; if (obs3 !== RST_VEC || cpu_stall3 !== 1'b0) begin err++; $display("FAIL idle_after_reset: got %h exp %h", obs3, RST_VEC); end
    cmp++; if (u3.state_q !== IDLE) begin err++; $display("FAIL idle_state: got %0d exp 0", u3.state_q); end
  endtask

  task automatic test_cpu_read_lat1;
    int en = 0, ackc = 0;
    logic [8:0] e;
    @(negedge CLK);
    cpu_req = 1; cpu_rw = RW_READ; cpu_addr = 8'h12;
    exp_q.push_back({REQ_CPU, 8'hA5});
    for (int c = 1; c <= 10 && ackc == 0; c++) begin
      @(negedge CLK);
      if (mem_en1) begin
        en++;
        cmp++; if (mem_rw1 !== 1'b1 || mem_addr1 !== 8'h12) begin err++; $display("FAIL rd_bus: got rw=%b addr=%h exp rw=1 addr=12", mem_rw1, mem_addr1); end
      end
      if (cpu_ack1) begin
        ackc = c;
        e = exp_q.pop_front();
        cmp++; if (cpu_rdata1 !== e[7:0]) begin err++; $display("FAIL rd_data: got %h exp %h", cpu_rdata1, e[7:0]); end
        cmp++; if (cpu_stall1 !== 1'b0) begin err++; $display("FAIL rd_stall_ack: got %b exp 0", cpu_stall1); end
        cpu_req = 0;
      end else begin
        cmp++; if (cpu_stall1 !== 1'b1) begin err++; $display("FAIL rd_stall: got %b exp 1", cpu_stall1); end
      end
    end
    cmp++; if (ackc != 2) begin err++; $display("FAIL rd_latency: got %0d exp 2", ackc); end
    cmp++; if (en != 1) begin err++; $display("FAIL rd_en_cycles: got %0d exp 1", en); end
    cpu_req = 0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_ldr_write_lat3;
    int en = 0, strobes = 0, ackc = 0, w0 = wr3;
    logic [7:0] rd0 = cpu_rdata3;
    logic [8:0] e;
    @(negedge CLK);
    ldr_req = 1; ldr_rw = RW_WRITE; ldr_addr = 8'h40; ldr_wdata = 8'h3C;
    exp_q.push_back({REQ_LDR, 8'h3C});
    for (int c = 1; c <= 12 && ackc == 0; c++) begin
      @(negedge CLK);
      if (mem_en3) begin
        en++;
        if (!mem_rw3) begin
          strobes++;
          cmp++; if (en != 3) begin err++; $display("FAIL wr_strobe_pos: got %0d exp 3", en); end
        end
      end
      if (ldr_ack3) begin
        ackc = c;
        ldr_req = 0;
        e = exp_q.pop_front();
        cmp++; if (waddr3 !== 8'h40 || wdata3 !== e[7:0]) begin err++; $display("FAIL wr_mem: got %h@%h exp %h@40", wdata3, waddr3, e[7:0]); end
        cmp++; if (owner3 !== e[8]) begin err++; $display("FAIL wr_owner: got %b exp %b", owner3, e[8]); end
      end
    end
    cmp++; if (ackc != 4) begin err++; $display("FAIL wr_latency: got %0d exp 4", ackc); end
    cmp++; if (en != 3) begin err++; $display("FAIL wr_en_cycles: got %0d exp 3", en); end
    cmp++; if (strobes != 1 || wr3 - w0 != 1) begin err++; $display("FAIL wr_count: got %0d/%0d exp 1/1", strobes, wr3 - w0); end
    cmp++; if (cpu_rdata3 !== rd0) begin err++; $display("FAIL wr_cpu_rdata: got %h exp %h", cpu_rdata3, rd0); end
    ldr_req = 0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_grant_order;
    int n = 0;
    logic [8:0] e;
    for (int i = 0; i < 10; i++)
      exp_q.push_back((i % 5 == 4) ? {REQ_CPU, pat(8'h01)} : {REQ_LDR, pat(8'h02)});
    @(negedge CLK);
    cpu_req = 1; cpu_rw = RW_READ; cpu_addr = 8'h01;
    ldr_req = 1; ldr_rw = RW_READ; ldr_addr = 8'h02;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge CLK);
      cmp++; if (cpu_ack3 && ldr_ack3) begin err++; $display("FAIL ack_overlap: got 11 exp one-hot"); end
      if (cpu_ack3 || ldr_ack3) begin
        e = exp_q.pop_front();
        cmp++; if (ldr_ack3 !== e[8] || owner3 !== e[8]) begin err++; $display("FAIL grant_order[%0d]: got ldr=%b exp %b", n, ldr_ack3, e[8]); end
        cmp++; if ((ldr_ack3 ? ldr_rdata3 : cpu_rdata3) !== e[7:0]) begin err++; $display("FAIL order_data[%0d]: got %h exp %h", n, ldr_ack3 ? ldr_rdata3 : cpu_rdata3, e[7:0]); end
        n++;
        if (n == 10) begin cpu_req = 0; ldr_req = 0; end
      end
    end
    cmp++; if (n != 10) begin err++; $display("FAIL order_timeout: got %0d acks exp 10", n); end
    cpu_req = 0; ldr_req = 0;
    exp_q.delete();
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_simultaneous;
    int n = 0;
    logic [8:0] e;
    exp_q.push_back({REQ_LDR, pat(8'h22)});
    exp_q.push_back({REQ_CPU, pat(8'h21)});
    @(negedge CLK);
    cpu_req = 1; cpu_rw = RW_READ; cpu_addr = 8'h21;
    ldr_req = 1; ldr_rw = RW_READ; ldr_addr = 8'h22;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge CLK);
      if (cpu_ack3 || ldr_ack3) begin
        e = exp_q.pop_front();
        cmp++; if (ldr_ack3 !== e[8]) begin err++; $display("FAIL simul_order[%0d]: got ldr=%b exp %b", n, ldr_ack3, e[8]); end
        cmp++; if ((ldr_ack3 ? ldr_rdata3 : cpu_rdata3) !== e[7:0]) begin err++; $display("FAIL simul_data[%0d]: got %h exp %h", n, ldr_ack3 ? ldr_rdata3 : cpu_rdata3, e[7:0]); end
        cmp++; if (u3.u_pick.starve_q !== 3'(n == 0)) begin err++; $display("FAIL simul_starve[%0d]: got %0d exp %0d", n, u3.u_pick.starve_q, n == 0); end
        if (ldr_ack3) ldr_req = 0;
        if (cpu_ack3) cpu_req = 0;
        n++;
      end
    end
    cmp++; if (n != 2) begin err++; $display("FAIL simul_timeout: got %0d acks exp 2", n); end
    cpu_req = 0; ldr_req = 0;
    exp_q.delete();
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_reset_mid_access;
    int w0 = wr3, acks = 0, en = 0;
    @(negedge CLK);
    ldr_req = 1; ldr_rw = RW_WRITE; ldr_addr = 8'h50; ldr_wdata = 8'h77;
    repeat (2) @(negedge CLK);
    cmp++; if (mem_en3 !== 1'b1) begin err++; $display("FAIL rstmid_in_access: got en=%b exp 1", mem_en3); end
    RST_N = 0;
    #1;
    cmp++; if (obs3 !== RST_VEC) begin err++; $display("FAIL rstmid_async_u3: got %h exp %h", obs3, RST_VEC); end
    cmp++; if (obs1 !== RST_VEC) begin err++; $display("FAIL rstmid_async_u1: got %h exp %h", obs1, RST_VEC); end
    ldr_req = 0;
    @(negedge CLK);
    RST_N = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      acks += int'(ldr_ack3 | cpu_ack3);
      en += int'(mem_en3);
    end
    cmp++; if (acks != 0 || en != 0) begin err++; $display("FAIL rstmid_quiet: got acks=%0d en=%0d exp 0/0", acks, en); end
    cmp++; if (wr3 != w0) begin err++; $display("FAIL rstmid_no_write: got %0d writes exp 0", wr3 - w0); end
    cmp++; if (u3.state_q !== IDLE) begin err++; $display("FAIL rstmid_idle: got %0d exp 0", u3.state_q); end
  endtask

  task automatic test_req_drop;
    int en = 0, acks = 0, ackc = 0;
    logic [8:0] e;
    @(negedge CLK);
    cpu_req = 1; cpu_rw = RW_READ; cpu_addr = 8'h33;
    exp_q.push_back({REQ_CPU, pat(8'h33)});
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (c == 1) cpu_req = 0;
      en += int'(mem_en3);
      if (cpu_ack3 || ldr_ack3) begin
        acks++;
        ackc = c;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 9'h1FF;
        cmp++; if (cpu_ack3 !== 1'b1 || cpu_rdata3 !== e[7:0]) begin err++; $display("FAIL drop_data: got %h exp %h", cpu_rdata3, e[7:0]); end
      end
    end
    cmp++; if (acks != 1 || ackc != 4) begin err++; $display("FAIL drop_ack: got %0d acks at %0d exp 1 at 4", acks, ackc); end
    cmp++; if (en != 3) begin err++; $display("FAIL drop_en_cycles: got %0d exp 3", en); end
  endtask

  initial begin
    test_reset;
    test_cpu_read_lat1;
    test_ldr_write_lat3;
    test_grant_order;
    test_simultaneous;
    test_reset_mid_access;
    test_req_drop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
